// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg : shared defaults and helpers for the LFSR bit packer.  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

  localparam int WORD_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RUN_LIMIT_DEF  = 8;
  localparam int DROP_CNT_W     = 8;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  localparam drop_cnt_t DROP_CNT_MAX = '1;

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == DROP_CNT_MAX) ? v : v + drop_cnt_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_bit_packer_if.sv
// ----------------------------------------------------------------------------
// lfsr_bit_packer_if : packed-word valid/ready stream.  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lfsr_bit_packer_if
  import lfsr_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input  word_ready);
  modport slave  (input  word_out, input  word_valid, output word_ready);

endinterface

`default_nettype wire

// File: rtl/lfsr_word_fifo.sv
// ----------------------------------------------------------------------------
// lfsr_word_fifo : show-ahead synchronous FIFO, power-of-2 depth.  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_bit_packer.sv
// ----------------------------------------------------------------------------
// lfsr_bit_packer : packs a serial LFSR stream LSB-first into words, buffers,
// drops/counts on overflow. LFSR_PACKER_HEALTH_EN adds a stuck test. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr_bit_packer
  import lfsr_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RUN_LIMIT  = RUN_LIMIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  input  logic                        clear,
  lfsr_bit_packer_if.master           word_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output drop_cnt_t                   drop_cnt,
  output logic                        stuck_err
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] packed_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;

  // Right shift: after WORD_W accepted bits the first one sits in bit 0.
  assign packed_word = {bit_in, shreg};
  assign word_done   = (bit_cnt == CNT_W'(WORD_W - 1));
  assign push        = bit_valid && word_done;
  assign pop         = !empty && word_if.word_ready;
  assign drop        = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bit_valid) begin
      shreg   <= packed_word[WORD_W-1:1];
      bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  lfsr_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (packed_word),
    .pop   (pop),
    .dout  (word_if.word_out),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign word_if.word_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

`ifdef LFSR_PACKER_HEALTH_EN
  localparam int RUN_W = $clog2(RUN_LIMIT + 1);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             last_bit;

  // run_cnt==0 only before the first accepted bit after reset.
  always_comb begin
    run_next = run_cnt;
    if (run_cnt == '0 || bit_in != last_bit)
      run_next = RUN_W'(1);
    else if (run_cnt != RUN_W'(RUN_LIMIT))
      run_next = run_cnt + RUN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt   <= '0;
      last_bit  <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      if (bit_valid) begin
        run_cnt  <= run_next;
        last_bit <= bit_in;
      end
      if (clear)
        stuck_err <= 1'b0;
      else if (bit_valid && run_next == RUN_W'(RUN_LIMIT))
        stuck_err <= 1'b1;
    end
  end
`else
  assign stuck_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_bit_packer.sv
// ----------------------------------------------------------------------------
// tb_lfsr_bit_packer : randomized self-checking bench with a queue-based model.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_bit_packer;
  import lfsr_pkg::*;

  localparam int W  = WORD_W_DEF;
  localparam int D  = FIFO_DEPTH_DEF;
  localparam int RL = RUN_LIMIT_DEF;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 bit_in = 1'b0;
  logic                 bit_valid = 1'b0;
  logic                 clear = 1'b0;
  logic [$clog2(D):0]   fifo_count;
  logic                 overflow;
  logic [7:0]           drop_cnt;
  logic                 stuck_err;

  lfsr_bit_packer_if #(.WORD_W(W)) wif ();

  lfsr_bit_packer #(.WORD_W(W), .FIFO_DEPTH(D), .RUN_LIMIT(RL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clear      (clear),
    .word_if    (wif.master),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .stuck_err  (stuck_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending bits, stored words, every completed word.
  bit           pend[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] gen[$];
  int           m_drop = 0;
  bit           m_ovf = 0;
  bit           m_stuck = 0;
  int           m_run = 0;
  bit           m_last = 0;

  task automatic model_reset();
    pend.delete(); mq.delete(); gen.delete();
    m_drop = 0; m_ovf = 0; m_stuck = 0; m_run = 0; m_last = 0;
  endtask

  // One clock: model consumes the inputs present at the edge, then settle.
  task automatic cycle();
    bit           full_before;
    bit           popping;
    logic [W-1:0] w;
    @(posedge clk);
    full_before = (mq.size() == D);
    popping     = (mq.size() > 0) && wif.word_ready;
    if (popping) void'(mq.pop_front());
    if (bit_valid) begin
      pend.push_back(bit_in);
      m_run  = (m_run > 0 && bit_in == m_last) ? ((m_run < RL) ? m_run + 1 : RL) : 1;
      m_last = bit_in;
`ifdef LFSR_PACKER_HEALTH_EN
      if (m_run == RL) m_stuck = 1;
`endif
      if (pend.size() == W) begin
        w = '0;
        for (int i = 0; i < W; i++) w[i] = pend[i];
        pend.delete();
        gen.push_back(w);
        if (!full_before || popping) mq.push_back(w);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (clear) begin m_ovf = 0; m_drop = 0; m_stuck = 0; end
    #1;
  endtask

  task automatic send(input bit b);
    bit_in = b; bit_valid = 1'b1;
    cycle();
  endtask

  task automatic pulse_clear();
    bit_valid = 1'b0; clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wif.word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wif.word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", wif.word_valid); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (wif.word_out !== '0) begin errors++; $display("FAIL reset_word: got %h want 0", wif.word_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (stuck_err !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %b want 0", stuck_err); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    bit bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    wif.word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(bits[i]);
      if (i == 6) begin
        checks++; if (wif.word_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", wif.word_valid); end
      end
    end
    bit_valid = 1'b0;
    checks++; if (wif.word_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", wif.word_valid); end
    checks++; if (wif.word_out !== 8'h4D) begin errors++; $display("FAIL single_word: got %h want 4d", wif.word_out); end
    checks++; if (fifo_count !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    cycle();
    checks++; if (fifo_count !== 0 || wif.word_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got count %0d valid %b want 0 0", fifo_count, wif.word_valid); end
  endtask

  task automatic test_overflow();
    pulse_clear();
    wif.word_ready = 1'b0; gen.delete();
    for (int i = 0; i < 5 * W; i++) send(1'($urandom));
    bit_valid = 1'b0;
    checks++; if (fifo_count !== D) begin errors++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, D); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
    wif.word_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      checks++; if (wif.word_valid !== 1'b1 || wif.word_out !== gen[i]) begin errors++; $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, wif.word_valid, wif.word_out, gen[i]); end
      cycle();
    end
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL ovf_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_full_push_pop();
    int prev_drop;
    pulse_clear();
    wif.word_ready = 1'b0; gen.delete();
    for (int i = 0; i < D * W + W - 1; i++) send(1'($urandom));
    checks++; if (fifo_count !== D) begin errors++; $display("FAIL fpp_prefill: got %0d want %0d", fifo_count, D); end
    prev_drop = m_drop;
    wif.word_ready = 1'b1;
    send(1'($urandom));
    bit_valid = 1'b0;
    checks++; if (fifo_count !== D) begin errors++; $display("FAIL fpp_count: got %0d want %0d", fifo_count, D); end
    checks++; if (drop_cnt !== 8'(prev_drop) || overflow !== 1'b0) begin errors++; $display("FAIL fpp_drop: got %0d/%b want %0d/0", drop_cnt, overflow, prev_drop); end
    for (int i = 1; i <= D; i++) begin
      checks++; if (wif.word_out !== gen[i]) begin errors++; $display("FAIL fpp_word%0d: got %h want %h", i, wif.word_out, gen[i]); end
      cycle();
    end
  endtask

  task automatic test_saturate_clear();
    pulse_clear();
    wif.word_ready = 1'b0;
    for (int i = 0; i < 300 * W; i++) send(1'($urandom));
    bit_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", overflow); end
    pulse_clear();
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0d/%b want 0/0", drop_cnt, overflow); end
    checks++; if (fifo_count !== D) begin errors++; $display("FAIL sat_keep: got %0d want %0d", fifo_count, D); end
    wif.word_ready = 1'b1;
    repeat (D) cycle();
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL sat_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_random();
    int ready_pct;
    for (int n = 0; n < 3000; n++) begin
      ready_pct      = ((n / 500) % 2 == 0) ? 80 : 15;
      bit_valid      = ($urandom_range(0, 3) != 0);
      bit_in         = 1'($urandom);
      wif.word_ready = ($urandom_range(0, 99) < ready_pct);
      clear          = ($urandom_range(0, 63) == 0);
      cycle();
      checks++;
      if (fifo_count !== ($clog2(D)+1)'(mq.size()) || wif.word_valid !== (mq.size() > 0)
          || overflow !== m_ovf || drop_cnt !== 8'(m_drop) || stuck_err !== m_stuck
          || (mq.size() > 0 && wif.word_out !== mq[0])) begin
        errors++;
        $display("FAIL random@%0d: got cnt %0d val %b word %h ovf %b drop %0d stuck %b want cnt %0d ovf %b drop %0d stuck %b head %h",
                 n, fifo_count, wif.word_valid, wif.word_out, overflow, drop_cnt, stuck_err,
                 mq.size(), m_ovf, m_drop, m_stuck, (mq.size() > 0) ? mq[0] : '0);
      end
    end
    clear = 1'b0; bit_valid = 1'b0; wif.word_ready = 1'b1;
    // Flush the partial word so the next test starts on a word boundary.
    while (pend.size() != 0) send(1'b0);
    bit_valid = 1'b0;
    repeat (D + 1) cycle();
  endtask

`ifdef LFSR_PACKER_HEALTH_EN
  task automatic test_health();
    logic [3:0] lfsr = 4'b0001;
    send(1'b0);
    pulse_clear();
    for (int i = 0; i < RL; i++) begin
      send(1'b1);
      if (i == RL - 2) begin
        checks++; if (stuck_err !== 1'b0) begin errors++; $display("FAIL stuck_early: got %b want 0", stuck_err); end
      end
    end
    checks++; if (stuck_err !== 1'b1) begin errors++; $display("FAIL stuck_set: got %b want 1", stuck_err); end
    send(1'b0);
    pulse_clear();
    for (int i = 0; i < 200; i++) begin
      send(lfsr[0]);
      lfsr = {lfsr[0] ^ lfsr[1], lfsr[3:1]};
    end
    bit_valid = 1'b0;
    checks++; if (stuck_err !== 1'b0) begin errors++; $display("FAIL stuck_lfsr: got %b want 0", stuck_err); end
    while (pend.size() != 0) send(1'b0);
    bit_valid = 1'b0;
    repeat (D + 1) cycle();
  endtask
`endif

  task automatic test_reset_mid_word();
    wif.word_ready = 1'b0;
    for (int i = 0; i < W + 3; i++) send(1'($urandom));
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wif.word_valid !== 1'b0 || fifo_count !== 0 || wif.word_out !== '0) begin errors++; $display("FAIL mid_reset: got val %b cnt %0d word %h want 0 0 0", wif.word_valid, fifo_count, wif.word_out); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 0 || stuck_err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %b %0d %b want 0 0 0", overflow, drop_cnt, stuck_err); end
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < W; i++) send(1'($urandom));
    bit_valid = 1'b0;
    checks++; if (wif.word_valid !== 1'b1 || fifo_count !== 1) begin errors++; $display("FAIL mid_fresh_count: got val %b cnt %0d want 1 1", wif.word_valid, fifo_count); end
    checks++; if (wif.word_out !== gen[0]) begin errors++; $display("FAIL mid_fresh_word: got %h want %h", wif.word_out, gen[0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_full_push_pop();
    test_saturate_clear();
    test_random();
`ifdef LFSR_PACKER_HEALTH_EN
    test_health();
`endif
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_bit_packer.md
# lfsr_bit_packer

Downstream consumer of the 4-bit LFSR's serial `output_bit`: collects the bit stream into WORD_W-bit words, buffers them in a small FIFO and hands them to the next stage over a valid/ready handshake. Upstream LFSR is free-running and never stalls, so this block absorbs backpressure, drops whole words on overflow and counts the drops. An optional health test flags a stuck bit stream.

## Interface
- WORD_W, 8, bits per packed word (2..32)
- FIFO_DEPTH, 4, word buffer entries (power of 2, ≥2)
- RUN_LIMIT, 8, consecutive identical bits that trip the stuck test (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- bit_in  in  1  serial bit, connected to LFSR `output_bit`
- bit_valid  in  1  bit_in is sampled this cycle
- clear  in  1  synchronous clear of overflow, drop_cnt, stuck_err
- word_out  out  WORD_W  FIFO head word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts word_out this cycle
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words stored
- overflow  out  1  sticky: a completed word was dropped
- drop_cnt  out  8  dropped-word count, saturating at 255
- stuck_err  out  1  sticky stuck-stream flag (only with macro)

## Operation
- Packer: shift register + bit counter 0..WORD_W-1. Bit accepted on each edge with bit_valid=1. LSB-first: first accepted bit lands in word bit 0.
- On the edge accepting the WORD_W-th bit, the completed word (including that bit) is pushed; counter wraps to 0, and the next bit starts a new word in the same cycle sequence (no gap).
- FIFO: show-ahead; word_out = head, valid when word_valid=1. Pop = word_valid & word_ready. word_out is don't-care when word_valid=0.
- Push accepted if fifo_count < FIFO_DEPTH, or if full and a pop occurs on the same edge (count unchanged).
- Full, no pop, push: word discarded, FIFO contents unchanged, overflow←1, drop_cnt+1 (saturate at 255). Packer continues; the partial word after the drop starts clean.
- Simultaneous push/pop when empty impossible (word_valid=0 → no pop); push only.
- clear: overflow, drop_cnt, stuck_err → 0 that edge; if a drop coincides with clear, clear wins for overflow/stuck_err, drop_cnt → 0. clear does not touch FIFO or packer.
- bit_valid=0: packer holds; FIFO still drains.

## Timing
- Reset (async assert, sync-release assumed by system): word_valid=0, fifo_count=0, overflow=0, drop_cnt=0, stuck_err=0, word_out=0, bit counter=0, run counter=0. Partial word and FIFO contents lost.
- Latency: word_valid rises the cycle after the edge accepting the last bit (1 cycle).
- fifo_count updates on the same edge as push/pop.
- Reset mid-word or mid-handshake: all state cleared immediately, no word emitted.

## Configuration
- `LFSR_PACKER_HEALTH_EN` defined: run counter tracks consecutive identical accepted bits; when the run length reaches RUN_LIMIT, stuck_err sets (sticky until clear/reset). The run counter resets to 1 on bit change and saturates at RUN_LIMIT. A healthy 4-bit maximal LFSR has maximum run 4, so default RUN_LIMIT=8 never trips.
- Undefined: no run counter; stuck_err tied 0.

## Structure
- Shared package `lfsr_pkg`: default WORD_W, FIFO_DEPTH, RUN_LIMIT constants; DROP_CNT_W=8.
- One sub-module: `lfsr_word_fifo` (show-ahead synchronous FIFO, parameterised width/depth, push/pop/full/empty/count). Packer, drop logic and health test live in the top.

## Test plan
- Bits 1,0,1,1,0,0,1,0 with bit_valid=1, word_ready=1 → word_out=0x4D, word_valid high exactly one cycle after 8th bit, fifo_count returns to 0.
- word_ready=0, 5 full words streamed, FIFO_DEPTH=4 → fifo_count=4, overflow=1, drop_cnt=1; then drain → first 4 words in order.
- Full FIFO, push and pop on same edge → no drop, fifo_count stays 4, drop_cnt unchanged.
- Keep word_ready=0 for 300 words → drop_cnt=255 (saturated); pulse clear → overflow=0, drop_cnt=0.
- With LFSR_PACKER_HEALTH_EN: drive bit_in=1 for 8 accepted bits → stuck_err=1 after 8th; real LFSR4bit stream for 200 cycles → stuck_err stays 0.
- Assert rst low after 3 bits of a word → all outputs at reset values; after release, next 8 bits form a fresh word.
